// File: rtl/nco_pwm_dac_if.sv
// Control and output bundle for the NCO PWM / sigma-delta DAC.
// The master side drives the upstream controls and the DAC slave side drives the outputs.
interface nco_pwm_dac_if;
  logic       i_enable;
  logic [7:0] i_sample_in;
  logic       i_sample_valid;
  logic       i_mode;
  logic [3:0] i_prescale;
  logic       i_clear_flags;
  logic       o_pwm_out;
  logic       o_period_start;
  logic       o_overrun;

  modport master (
    output i_enable, i_sample_in, i_sample_valid, i_mode, i_prescale, i_clear_flags,
    input  o_pwm_out, o_period_start, o_overrun
  );

  modport slave (
    input  i_enable, i_sample_in, i_sample_valid, i_mode, i_prescale, i_clear_flags,
    output o_pwm_out, o_period_start, o_overrun
  );
endinterface

// File: rtl/nco_pwm_dac.sv
// 1-bit DAC driven by a double-buffered 8-bit sample.
// It outputs either a 256-tick PWM frame or a first-order sigma-delta stream, and the tick rate is set by a prescaler.
module nco_pwm_dac (
  input  logic          clk,
  input  logic          rst_n,
  nco_pwm_dac_if.slave  bus
);

  logic [3:0] r_psc;
  logic [7:0] r_cnt;
  logic [7:0] r_acc;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic [7:0] r_active;
  logic       r_mode_act;
  logic       r_pwm;
  logic       r_period_start;
  logic       r_overrun;

  logic       w_tick;
  logic       w_wrap;
  logic       w_load;
  logic       w_overrun_evt;
  logic [7:0] w_active_nxt;
  logic       w_mode_nxt;
  logic [7:0] w_duty;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_acc_base;
  logic [8:0] w_sum;

  assign w_tick        = bus.i_enable && (r_psc == bus.i_prescale);
  assign w_wrap        = w_tick && (r_cnt == 8'hFF);
  assign w_load        = bus.i_enable && bus.i_sample_valid;
  assign w_overrun_evt = w_load && r_hold_valid && !w_wrap;

  // The wrap tick already emits the first slot of the new frame, so it uses the incoming sample and mode.
  assign w_active_nxt  = (w_wrap && r_hold_valid) ? r_hold : r_active;
  assign w_mode_nxt    = w_wrap ? bus.i_mode : r_mode_act;
  assign w_duty        = w_active_nxt ^ 8'h80;
  assign w_cnt_nxt     = r_cnt + 8'd1;
  assign w_acc_base    = (w_wrap && (bus.i_mode != r_mode_act)) ? 8'h00 : r_acc;
  assign w_sum         = {1'b0, w_acc_base} + {1'b0, w_duty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc          <= 4'd0;
      r_cnt          <= 8'd0;
      r_acc          <= 8'd0;
      r_hold         <= 8'd0;
      r_hold_valid   <= 1'b0;
      r_active       <= 8'h00;
      r_mode_act     <= 1'b0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (bus.i_enable) begin
      // Counts past a lowered prescale run on to 15 and wrap without ticking.
      r_psc          <= w_tick ? 4'd0 : r_psc + 4'd1;
      r_period_start <= w_wrap;

      if (w_load) begin
        r_hold       <= bus.i_sample_in;
        r_hold_valid <= 1'b1;
      end else if (w_wrap) begin
        r_hold_valid <= 1'b0;
      end

      if (w_overrun_evt)
        r_overrun <= 1'b1;
      else if (bus.i_clear_flags)
        r_overrun <= 1'b0;

      if (w_tick) begin
        r_cnt      <= w_cnt_nxt;
        r_active   <= w_active_nxt;
        r_mode_act <= w_mode_nxt;
        if (w_mode_nxt) begin
          r_acc <= w_sum[7:0];
          r_pwm <= w_sum[8];
        end else begin
          r_acc <= w_acc_base;
          r_pwm <= (w_cnt_nxt < w_duty);
        end
      end
    end
  end

  assign bus.o_pwm_out      = r_pwm;
  assign bus.o_period_start = r_period_start;
  assign bus.o_overrun      = r_overrun;

endmodule

// File: tb/tb_nco_pwm_dac.sv
// Directed bench for nco_pwm_dac.
// Frame duty counts, frame spacing, overrun flag behaviour, sigma-delta pattern, freeze and asynchronous reset.
module tb_nco_pwm_dac;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic bits [0:1023];

  nco_pwm_dac_if bus ();

  nco_pwm_dac dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_step(input logic [7:0] data);
    bus.i_sample_valid = 1'b1;
    bus.i_sample_in    = data;
    step();
    bus.i_sample_valid = 1'b0;
  endtask

  // Steps until period_start is seen and returns the number of cycles taken (capped at budget).
  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.o_period_start !== 1'b1 && n < budget);
  endtask

  // Called at a frame start; samples len cycles and ends at the following frame start.
  task automatic measure_frame(input int len, input bit send, input logic [7:0] data,
                               output int highs, output int pss);
    highs = 0;
    pss   = 0;
    for (int i = 0; i < len; i++) begin
      bits[i] = bus.o_pwm_out;
      if (bus.o_pwm_out === 1'b1) highs++;
      if (bus.o_period_start === 1'b1) pss++;
      if (i == 0 && send) send_step(data);
      else step();
    end
  endtask

  initial begin
    int n, highs, pss, perr, changes;
    logic p0;

    rst_n              = 1'b0;
    bus.i_enable       = 1'b0;
    bus.i_sample_in    = 8'h00;
    bus.i_sample_valid = 1'b0;
    bus.i_mode         = 1'b0;
    bus.i_prescale     = 4'd0;
    bus.i_clear_flags  = 1'b0;
    step();
    step();
    check("rst_pwm", bus.o_pwm_out, 0);
    check("rst_period_start", bus.o_period_start, 0);
    check("rst_overrun", bus.o_overrun, 0);

    rst_n        = 1'b1;
    bus.i_enable = 1'b1;
    send_step(8'h00);
    wait_ps(300, n);
    check("first_wrap_cycles", n, 255);

    measure_frame(256, 1'b1, 8'h80, highs, pss);
    check("frame_00_highs", highs, 128);
    check("frame_00_ps_count", pss, 1);
    check("frame_00_next_ps", bus.o_period_start, 1);
    check("no_overrun_single", bus.o_overrun, 0);

    measure_frame(256, 1'b1, 8'h7F, highs, pss);
    check("frame_80_highs", highs, 0);
    check("frame_80_next_ps", bus.o_period_start, 1);

    measure_frame(256, 1'b0, 8'h00, highs, pss);
    check("frame_7f_highs", highs, 255);

    measure_frame(256, 1'b0, 8'h00, highs, pss);
    check("frame_repeat_highs", highs, 255);

    // Two samples in one frame: the second overwrites the first.
    send_step(8'h40);
    step();
    send_step(8'hC0);
    check("overrun_set", bus.o_overrun, 1);
    wait_ps(300, n);
    check("overrun_wrap_cycles", n, 253);
    measure_frame(256, 1'b0, 8'h00, highs, pss);
    check("overrun_second_used", highs, 64);
    check("overrun_sticky", bus.o_overrun, 1);

    bus.i_clear_flags = 1'b1;
    step();
    bus.i_clear_flags = 1'b0;
    check("clear_overrun", bus.o_overrun, 0);
    send_step(8'hC0);
    check("first_sample_no_overrun", bus.o_overrun, 0);
    bus.i_clear_flags = 1'b1;
    send_step(8'hC0);
    bus.i_clear_flags = 1'b0;
    check("set_wins_over_clear", bus.o_overrun, 1);
    bus.i_clear_flags = 1'b1;
    step();
    bus.i_clear_flags = 1'b0;
    check("clear_again", bus.o_overrun, 0);

    // Sample coincident with the wrap tick while the buffer is full.
    wait_ps(300, n);
    check("pre_coincide_wrap_cycles", n, 252);
    send_step(8'h00);
    for (int i = 0; i < 254; i++) step();
    send_step(8'h80);
    check("coincide_is_wrap", bus.o_period_start, 1);
    check("coincide_no_overrun", bus.o_overrun, 0);
    measure_frame(256, 1'b0, 8'h00, highs, pss);
    check("coincide_old_hold_highs", highs, 128);

    bus.i_mode = 1'b1;
    measure_frame(256, 1'b1, 8'hC0, highs, pss);
    check("coincide_new_hold_highs", highs, 0);

    measure_frame(256, 1'b0, 8'h00, highs, pss);
    check("sd_c0_highs", highs, 64);
    perr = 0;
    for (int i = 0; i < 256; i++)
      if (bits[i] !== ((i % 4) == 3)) perr++;
    check("sd_c0_pattern_errors", perr, 0);

    // Prescale 3: one tick every 4 cycles, frames of 1024 cycles.
    bus.i_mode     = 1'b0;
    bus.i_prescale = 4'd3;
    send_step(8'h40);
    wait_ps(1100, n);
    check("psc3_wrap_cycles", n, 1023);
    measure_frame(1024, 1'b0, 8'h00, highs, pss);
    check("psc3_frame_high_cycles", highs, 768);
    check("psc3_ps_count", pss, 1);
    check("psc3_next_ps", bus.o_period_start, 1);

    // Freeze for 50 cycles mid-frame and resume where the count stopped.
    for (int i = 0; i < 100; i++) step();
    check("pre_freeze_pwm", bus.o_pwm_out, 1);
    bus.i_enable = 1'b0;
    p0      = bus.o_pwm_out;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.o_pwm_out !== p0 || bus.o_period_start !== 1'b0) changes++;
    end
    check("freeze_outputs_hold", changes, 0);
    bus.i_enable = 1'b1;
    wait_ps(1100, n);
    check("resume_wrap_cycles", n, 924);

    // Buffer a sample (with overrun), freeze, then reset asynchronously between edges.
    send_step(8'h7F);
    send_step(8'h80);
    check("pre_reset_overrun", bus.o_overrun, 1);
    for (int i = 0; i < 98; i++) step();
    check("pre_reset_pwm", bus.o_pwm_out, 1);
    bus.i_enable = 1'b0;
    step();
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", bus.o_pwm_out, 0);
    check("async_rst_period_start", bus.o_period_start, 0);
    check("async_rst_overrun", bus.o_overrun, 0);
    step();
    rst_n        = 1'b1;
    bus.i_enable = 1'b1;
    wait_ps(1100, n);
    check("post_reset_wrap_cycles", n, 1024);
    measure_frame(1024, 1'b0, 8'h00, highs, pss);
    check("post_reset_midscale_cycles", highs, 512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
